// File: rtl/apb_to_ahbl.sv
// APB3 completer to AHB-Lite manager bridge.
// Each APB transfer becomes exactly one word-sized AHB-Lite SINGLE transfer.
// Only one transfer is in flight at a time. The APB access phase is held
// with pready=0 until the AHB data phase completes.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   apbs_*             APB3 completer interface (psel/penable/pwrite/paddr/pwdata in,
//                      prdata/pready/pslverr out)
//   ahblm_*            AHB-Lite manager interface (haddr/hwrite/htrans/hsize/hburst/
//                      hprot/hmastlock/hwdata out, hready/hresp/hrdata in)
module apb_to_ahbl #(
    parameter int unsigned         W_PADDR    = 16,
    parameter int unsigned         W_HADDR    = 32,
    parameter logic [W_HADDR-1:0]  HADDR_BASE = '0,
    parameter logic [3:0]          HPROT_VAL  = 4'b0011
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 apbs_psel,
    input  logic                 apbs_penable,
    input  logic                 apbs_pwrite,
    input  logic [W_PADDR-1:0]   apbs_paddr,
    input  logic [31:0]          apbs_pwdata,
    output logic [31:0]          apbs_prdata,
    output logic                 apbs_pready,
    output logic                 apbs_pslverr,

    output logic [W_HADDR-1:0]   ahblm_haddr,
    output logic                 ahblm_hwrite,
    output logic [1:0]           ahblm_htrans,
    output logic [2:0]           ahblm_hsize,
    output logic [2:0]           ahblm_hburst,
    output logic [3:0]           ahblm_hprot,
    output logic                 ahblm_hmastlock,
    input  logic                 ahblm_hready,
    input  logic                 ahblm_hresp,
    output logic [31:0]          ahblm_hwdata,
    input  logic [31:0]          ahblm_hrdata
);

    localparam int unsigned W_DATA = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10,
        S_RESP = 2'b11
    } state_e;

    state_e              state_q,   state_d;
    logic [W_HADDR-1:0]  haddr_q,   haddr_d;
    logic                hwrite_q,  hwrite_d;
    logic [1:0]          htrans_q,  htrans_d;
    logic [W_DATA-1:0]   wdata_q,   wdata_d;
    logic [W_DATA-1:0]   hwdata_q,  hwdata_d;
    logic [W_DATA-1:0]   prdata_q,  prdata_d;
    logic                pready_q,  pready_d;
    logic                pslverr_q, pslverr_d;

    // Byte-offset bits of paddr never reach the AHB side; transfers are word-aligned.
    logic [1:0]          unused_paddr_lsbs;
    assign unused_paddr_lsbs = apbs_paddr[1:0];

    // Word-aligned AHB address for the APB address presented in setup.
    logic [W_HADDR-1:0]  haddr_setup;
    assign haddr_setup = HADDR_BASE | W_HADDR'({apbs_paddr[W_PADDR-1:2], 2'b00});

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            htrans_q  <= HTRANS_IDLE;
            wdata_q   <= '0;
            hwdata_q  <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            htrans_q  <= htrans_d;
            wdata_q   <= wdata_d;
            hwdata_q  <= hwdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Next-state and next-output decode; registered outputs reflect the state being entered.
    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        htrans_d  = HTRANS_IDLE;
        wdata_d   = wdata_q;
        hwdata_d  = hwdata_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = pslverr_q;

        case (state_q)
            S_IDLE: begin
                pslverr_d = 1'b0;
                // Only a genuine setup phase starts a transfer; a lone penable is ignored.
                if (apbs_psel && !apbs_penable) begin
                    haddr_d  = haddr_setup;
                    hwrite_d = apbs_pwrite;
                    wdata_d  = apbs_pwdata;
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                // NONSEQ stays on the bus until the fabric accepts the address phase.
                htrans_d = HTRANS_NONSEQ;
                if (ahblm_hready) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_q;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                // The first cycle of a two-cycle error has hready=0 and is simply waited out.
                if (ahblm_hready) begin
                    if (!hwrite_q) begin
                        prdata_d = ahblm_hrdata;
                    end
                    pslverr_d = ahblm_hresp;
                    pready_d  = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                pslverr_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign apbs_prdata     = prdata_q;
    assign apbs_pready     = pready_q;
    assign apbs_pslverr    = pslverr_q;

    assign ahblm_haddr     = haddr_q;
    assign ahblm_hwrite    = hwrite_q;
    assign ahblm_htrans    = htrans_q;
    assign ahblm_hwdata    = hwdata_q;
    assign ahblm_hsize     = HSIZE_WORD;
    assign ahblm_hburst    = HBURST_SINGLE;
    assign ahblm_hprot     = HPROT_VAL;
    assign ahblm_hmastlock = 1'b0;

endmodule

// File: tb/tb_apb_to_ahbl.sv
// Self-checking bench for apb_to_ahbl: directed APB transfers against a scripted
// AHB-Lite completer, expected APB responses queued at setup and checked at pready.
module tb_apb_to_ahbl;

    logic        clk;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic        hready, hresp;
    logic [31:0] hwdata, hrdata;

    // Second instance with a non-zero base; only its haddr is observed.
    logic [31:0] haddr2;
    logic [31:0] unused_prdata2, unused_hwdata2;
    logic        unused_pready2, unused_pslverr2, unused_hwrite2, unused_hmastlock2;
    logic [1:0]  unused_htrans2;
    logic [2:0]  unused_hsize2, unused_hburst2;
    logic [3:0]  unused_hprot2;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pslverr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_rd = 32'h0;

    apb_to_ahbl dut (
        .clk(clk), .rst_n(rst_n),
        .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
        .apbs_paddr(paddr), .apbs_pwdata(pwdata), .apbs_prdata(prdata),
        .apbs_pready(pready), .apbs_pslverr(pslverr),
        .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
        .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
        .ahblm_hmastlock(hmastlock), .ahblm_hready(hready), .ahblm_hresp(hresp),
        .ahblm_hwdata(hwdata), .ahblm_hrdata(hrdata)
    );

    apb_to_ahbl #(.HADDR_BASE(32'h4000_0000)) dut_base (
        .clk(clk), .rst_n(rst_n),
        .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
        .apbs_paddr(paddr), .apbs_pwdata(pwdata), .apbs_prdata(unused_prdata2),
        .apbs_pready(unused_pready2), .apbs_pslverr(unused_pslverr2),
        .ahblm_haddr(haddr2), .ahblm_hwrite(unused_hwrite2), .ahblm_htrans(unused_htrans2),
        .ahblm_hsize(unused_hsize2), .ahblm_hburst(unused_hburst2), .ahblm_hprot(unused_hprot2),
        .ahblm_hmastlock(unused_hmastlock2), .ahblm_hready(hready), .ahblm_hresp(hresp),
        .ahblm_hwdata(unused_hwdata2), .ahblm_hrdata(hrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One APB transfer starting in the current (IDLE) cycle; returns in the IDLE cycle after RESP.
    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                        input int aw, input int dw, input logic err,
                        input logic [31:0] rd, input logic drop);
        exp_t        e;
        logic [31:0] ea;
        ea = {16'h0, addr[15:2], 2'b00};

        check("setup_htrans", 32'(htrans), 32'h0);
        check("setup_pready", 32'(pready), 32'h0);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        hready = 1'b1; hresp = 1'b0; hrdata = 32'hDEAD_BEEF;
        if (!wr) last_rd = rd;
        e.prdata  = last_rd;
        e.pslverr = err;
        sb.push_back(e);
        tick();

        penable = 1'b1;
        if (drop) psel = 1'b0;
        for (int i = 0; i <= aw; i++) begin
            check("addr_htrans", 32'(htrans), 32'h2);
            check("addr_haddr", haddr, ea);
            check("addr_haddr_base", haddr2, ea | 32'h4000_0000);
            check("addr_hwrite", 32'(hwrite), 32'(wr));
            check("addr_pready", 32'(pready), 32'h0);
            hready = (i == aw);
            tick();
        end

        for (int i = 0; i <= dw; i++) begin
            check("data_htrans", 32'(htrans), 32'h0);
            check("data_hwdata", hwdata, wd);
            check("data_pready", 32'(pready), 32'h0);
            hready = (i == dw);
            hresp  = err && (i + 1 >= dw);
            hrdata = (i == dw) ? rd : 32'hDEAD_BEEF;
            tick();
        end

        check("resp_pready", 32'(pready), 32'h1);
        check("resp_htrans", 32'(htrans), 32'h0);
        if (pready && sb.size() > 0) begin
            e = sb.pop_front();
            check("resp_prdata", prdata, e.prdata);
            check("resp_pslverr", 32'(pslverr), 32'(e.pslverr));
        end
        psel = 1'b0; penable = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
        tick();

        check("post_pready", 32'(pready), 32'h0);
        check("post_pslverr", 32'(pslverr), 32'h0);
        check("post_htrans", 32'(htrans), 32'h0);
        check("post_prdata_hold", prdata, last_rd);
    endtask

    initial begin
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0; pwdata = 32'h0;
        hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
        #12;
        check("rst_htrans", 32'(htrans), 32'h0);
        check("rst_haddr", haddr, 32'h0);
        check("rst_hwrite", 32'(hwrite), 32'h0);
        check("rst_hwdata", hwdata, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", 32'(pready), 32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("const_hsize", 32'(hsize), 32'h2);
        check("const_hburst", 32'(hburst), 32'h0);
        check("const_hprot", 32'(hprot), 32'h3);
        check("const_hmastlock", 32'(hmastlock), 32'h0);
        rst_n = 1'b1;
        tick();

        // Zero-wait write, then read with 2 data-phase waits (back-to-back).
        xfer(1'b1, 16'h0010, 32'hCAFE_F00D, 0, 0, 1'b0, 32'hFFFF_0000, 1'b0);
        xfer(1'b0, 16'h0024, 32'h0000_1111, 0, 2, 1'b0, 32'h1234_5678, 1'b0);
        // Unaligned address: low bits masked, base OR'd on the second instance.
        xfer(1'b0, 16'h4003, 32'h0000_2222, 0, 0, 1'b0, 32'hA5A5_0001, 1'b0);
        // Two-cycle error response on a write, then an OKAY read.
        xfer(1'b1, 16'h0040, 32'h0BAD_0BAD, 0, 1, 1'b1, 32'h7777_7777, 1'b0);
        xfer(1'b0, 16'h0100, 32'h0000_3333, 0, 0, 1'b0, 32'h3C3C_C3C3, 1'b0);
        // Address phase stalled 3 cycles.
        xfer(1'b1, 16'h0200, 32'h1122_3344, 3, 0, 1'b0, 32'h0, 1'b0);
        // Error on a read with address and data waits.
        xfer(1'b0, 16'h0204, 32'h0000_4444, 1, 2, 1'b1, 32'h9999_AAAA, 1'b0);
        // psel dropped after setup: transfer still completes.
        xfer(1'b0, 16'h0008, 32'h0000_5555, 0, 1, 1'b0, 32'h55AA_33CC, 1'b1);

        // penable without a setup phase is ignored.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0300;
        tick();
        check("stray_htrans0", 32'(htrans), 32'h0);
        tick();
        check("stray_htrans1", 32'(htrans), 32'h0);
        psel = 1'b0;
        tick();
        check("stray_htrans2", 32'(htrans), 32'h0);
        check("stray_pready", 32'(pready), 32'h0);
        penable = 1'b0;
        tick();

        // Reset asserted during a stalled data phase.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0050; pwdata = 32'h0F0F_F0F0;
        hready = 1'b1;
        tick();
        penable = 1'b1;
        tick();
        hready = 1'b0;
        tick();
        check("pre_rst_hwdata", hwdata, 32'h0F0F_F0F0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_htrans", 32'(htrans), 32'h0);
        check("mid_rst_pready", 32'(pready), 32'h0);
        check("mid_rst_haddr", haddr, 32'h0);
        check("mid_rst_hwdata", hwdata, 32'h0);
        check("mid_rst_prdata", prdata, 32'h0);
        psel = 1'b0; penable = 1'b0; hready = 1'b1;
        last_rd = 32'h0;
        tick();
        #2 rst_n = 1'b1;
        tick();

        xfer(1'b1, 16'h0030, 32'hDEAD_C0DE, 0, 0, 1'b0, 32'h0, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
